// File: rtl/msk_mcinv_sched_pkg.sv
// msk_mcinv_sched_pkg: FSM encoding, column constants and share-packed byte slicing
// shared by the masked InvMixColumns scheduler (optional MSK_MCINV_PIPE_EN build).
package msk_mcinv_sched_pkg;
    localparam int NCOL  = 4;
    localparam int COL_W = 2;
    typedef enum logic [1:0] {IDLE, RUN, PIPE, DONE} state_t;
endpackage

`ifndef MSK_BYTE
`define MSK_BYTE(j, d) (j)*8*(d) +: 8*(d)
`endif

// File: rtl/MSKaesMCinv.sv
// MSKaesMCinv: masked AES InvMixColumns on one column; the map is linear,
// so each share is processed on its own and share domains never mix.
module MSKaesMCinv #(parameter int d = 2) (
    input  logic [8*d-1:0] b0,
    input  logic [8*d-1:0] b1,
    input  logic [8*d-1:0] b2,
    input  logic [8*d-1:0] b3,
    output logic [8*d-1:0] a0,
    output logic [8*d-1:0] a1,
    output logic [8*d-1:0] a2,
    output logic [8*d-1:0] a3
);
    function automatic logic [7:0] xt(input logic [7:0] x);
        return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gm(input logic [7:0] x, input logic [3:0] k);
        logic [7:0] x2, x4, x8;
        x2 = xt(x);
        x4 = xt(x2);
        x8 = xt(x4);
        return ({8{k[0]}} & x) ^ ({8{k[1]}} & x2) ^ ({8{k[2]}} & x4) ^ ({8{k[3]}} & x8);
    endfunction

    for (genvar s = 0; s < d; s++) begin : g_sh
        logic [7:0] x0, x1, x2, x3;
        assign x0 = b0[8*s +: 8];
        assign x1 = b1[8*s +: 8];
        assign x2 = b2[8*s +: 8];
        assign x3 = b3[8*s +: 8];
        assign a0[8*s +: 8] = gm(x0, 4'he) ^ gm(x1, 4'hb) ^ gm(x2, 4'hd) ^ gm(x3, 4'h9);
        assign a1[8*s +: 8] = gm(x0, 4'h9) ^ gm(x1, 4'he) ^ gm(x2, 4'hb) ^ gm(x3, 4'hd);
        assign a2[8*s +: 8] = gm(x0, 4'hd) ^ gm(x1, 4'h9) ^ gm(x2, 4'he) ^ gm(x3, 4'hb);
        assign a3[8*s +: 8] = gm(x0, 4'hb) ^ gm(x1, 4'hd) ^ gm(x2, 4'h9) ^ gm(x3, 4'he);
    end
endmodule

// File: rtl/msk_mcinv_sched_col_mux.sv
// msk_mcinv_col_mux: splits column col of the share-packed state into four row buses.
module msk_mcinv_col_mux
    import msk_mcinv_sched_pkg::*;
#(parameter int d = 2) (
    input  logic [128*d-1:0] src,
    input  logic [COL_W-1:0] col,
    output logic [8*d-1:0]   b0,
    output logic [8*d-1:0]   b1,
    output logic [8*d-1:0]   b2,
    output logic [8*d-1:0]   b3
);
    logic [32*d-1:0] column;
    assign column = src[32*d*int'(col) +: 32*d];
    assign b0 = column[`MSK_BYTE(0, d)];
    assign b1 = column[`MSK_BYTE(1, d)];
    assign b2 = column[`MSK_BYTE(2, d)];
    assign b3 = column[`MSK_BYTE(3, d)];
endmodule

// File: rtl/msk_mcinv_sched.sv
// msk_mcinv_sched: streams one masked AES state through the shared column InvMixColumns
// datapath, one column per cycle. MSK_MCINV_PIPE_EN adds a register stage after the datapath.
module msk_mcinv_sched
    import msk_mcinv_sched_pkg::*;
#(parameter int d = 2) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             in_bypass,
    input  logic [128*d-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [128*d-1:0] out_data,
    output logic             busy
);
    state_t state_q, state_d;
    logic [COL_W-1:0] col_q, wcol;
    logic [128*d-1:0] src_q, dst_q;
    logic [8*d-1:0] b0, b1, b2, b3, a0, a1, a2, a3, w0, w1, w2, w3;
    logic accept, wen;

`ifdef MSK_MCINV_PIPE_EN
    localparam state_t LAST_NEXT = PIPE;
    logic [8*d-1:0] p0, p1, p2, p3;
    logic [COL_W-1:0] pcol_q;
    logic pwen_q;
    // Write side trails the datapath by one cycle; PIPE lets column 3 land.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            {p0, p1, p2, p3} <= '0;
            pcol_q <= '0;
            pwen_q <= 1'b0;
        end else begin
            {p0, p1, p2, p3} <= {a0, a1, a2, a3};
            pcol_q <= col_q;
            pwen_q <= state_q == RUN;
        end
    end
    assign {w0, w1, w2, w3} = {p0, p1, p2, p3};
    assign wcol = pcol_q;
    assign wen = pwen_q;
`else
    localparam state_t LAST_NEXT = DONE;
    assign {w0, w1, w2, w3} = {a0, a1, a2, a3};
    assign wcol = col_q;
    assign wen = state_q == RUN;
`endif

    assign accept = in_valid & in_ready;

    msk_mcinv_col_mux #(.d(d)) u_mux (
        .src(src_q), .col(col_q), .b0(b0), .b1(b1), .b2(b2), .b3(b3)
    );

    MSKaesMCinv #(.d(d)) u_mcinv (
        .b0(b0), .b1(b1), .b2(b2), .b3(b3), .a0(a0), .a1(a1), .a2(a2), .a3(a3)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    state_d = in_valid ? (in_bypass ? DONE : RUN) : IDLE;
            RUN:     state_d = (col_q == COL_W'(NCOL - 1)) ? LAST_NEXT : RUN;
            PIPE:    state_d = DONE;
            DONE:    state_d = out_ready ? IDLE : DONE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = state_q == IDLE;
        out_valid = state_q == DONE;
        busy      = state_q != IDLE;
    end

    // Inputs are only sampled on accept, so X on idle inputs never reaches state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col_q <= '0;
            src_q <= '0;
            dst_q <= '0;
        end else begin
            col_q <= accept ? '0 : (state_q == RUN) ? col_q + 1'b1 : col_q;
            if (accept) src_q <= in_data;
            if (accept && in_bypass) dst_q <= in_data;
            else if (wen) dst_q[32*d*int'(wcol) +: 32*d] <= {w3, w2, w1, w0};
        end
    end

    assign out_data = dst_q;
endmodule
